// File: rtl/audio_in_receiver_if.sv
// Captured left/right sample pair with valid/ready handshake toward the consumer.
interface audio_in_receiver_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] left_sample;
    logic [DATA_WIDTH-1:0] right_sample;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output left_sample,
        output right_sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  left_sample,
        input  right_sample,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/audio_in_receiver.sv
// I2S ADC capture: synchronises codec pins, deserialises left/right words, presents pairs one clk after the completing BCLK rise.
// A pair completing while the previous one is still unaccepted is dropped and flagged in the sticky overflow bit.
module audio_in_receiver #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                AUD_BCLK,
    input  logic                AUD_ADCLRCK,
    input  logic                AUD_ADCDAT,
    input  logic                enable,
    audio_in_receiver_if.master smp,
    output logic                overflow,
    output logic                frame_error,
    output logic [15:0]         frame_count
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        WAIT_FRAME,
        LEFT_DELAY,
        LEFT_SHIFT,
        RIGHT_DELAY,
        RIGHT_SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] adat_sync;
    logic                   bclk_prev;

    logic bclk_s;
    logic lr_s;
    logic dat_s;
    logic bclk_rise;
    logic lr_change;
    logic word_full;
    logic pair_complete;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] left_word;
    logic                  left_ok;
    logic                  lr_prev;
    logic                  lr_primed;

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lr_s      = lrck_sync[SYNC_STAGES-1];
    assign dat_s     = adat_sync[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev;
    assign word_full = (bit_cnt == FULL_CNT);

    // The first rise after reset only learns the LRCK level, so a reset inside
    // a left channel does not look like the start of a new frame.
    assign lr_change = lr_primed && (lr_s != lr_prev);

    assign pair_complete = enable && bclk_rise && (state == RIGHT_SHIFT) &&
                           lr_change && word_full && left_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            adat_sync <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
            adat_sync <= {adat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
            bclk_prev <= bclk_s;
        end
    end

    // The delay slot coincides with the LRCK-change rise, so the DELAY states
    // are folded into that rise and the register moves straight to SHIFT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_FRAME;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            left_word   <= '0;
            left_ok     <= 1'b0;
            lr_prev     <= 1'b1;
            lr_primed   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (bclk_rise) begin
                lr_prev   <= lr_s;
                lr_primed <= 1'b1;
            end

            if (!enable) begin
                state     <= WAIT_FRAME;
                bit_cnt   <= '0;
                shift_reg <= '0;
                left_ok   <= 1'b0;
            end else if (bclk_rise) begin
                case (state)
                    WAIT_FRAME: begin
                        if (lr_change && !lr_s) begin
                            state     <= LEFT_SHIFT;
                            bit_cnt   <= '0;
                            shift_reg <= '0;
                            left_ok   <= 1'b0;
                        end
                    end
                    LEFT_DELAY: begin
                        state <= LEFT_SHIFT;
                    end
                    RIGHT_DELAY: begin
                        state <= RIGHT_SHIFT;
                    end
                    LEFT_SHIFT: begin
                        if (lr_change) begin
                            state     <= RIGHT_SHIFT;
                            bit_cnt   <= '0;
                            shift_reg <= '0;
                            left_ok   <= word_full;
                            if (word_full) begin
                                left_word <= shift_reg;
                            end else begin
                                frame_error <= 1'b1;
                            end
                        end else if (!word_full) begin
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], dat_s};
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                        end
                    end
                    RIGHT_SHIFT: begin
                        if (lr_change) begin
                            state     <= LEFT_SHIFT;
                            bit_cnt   <= '0;
                            shift_reg <= '0;
                            left_ok   <= 1'b0;
                            if (!word_full) begin
                                frame_error <= 1'b1;
                            end
                        end else if (!word_full) begin
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], dat_s};
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= WAIT_FRAME;
                    end
                endcase
            end
        end
    end

    // A completion and an acceptance in the same cycle replace the pair in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            smp.left_sample  <= '0;
            smp.right_sample <= '0;
            smp.sample_valid <= 1'b0;
            overflow         <= 1'b0;
            frame_count      <= 16'd0;
        end else if (pair_complete && smp.sample_valid && !smp.sample_ready) begin
            overflow <= 1'b1;
        end else if (pair_complete) begin
            smp.left_sample  <= left_word;
            smp.right_sample <= shift_reg;
            smp.sample_valid <= 1'b1;
            frame_count      <= frame_count + 16'd1;
        end else if (smp.sample_valid && smp.sample_ready) begin
            smp.sample_valid <= 1'b0;
        end
    end

endmodule

// File: doc/audio_in_receiver.md
AUDIO_IN_RECEIVER -- requirements
Module: audio_in_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bits captured per channel.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for codec inputs, minimum 2.
REQ-003 SHALL have port clk, input, 1: the only clock in the block.
REQ-004 SHALL have port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port AUD_BCLK, input, 1: codec bit clock, asynchronous to clk.
REQ-006 SHALL have port AUD_ADCLRCK, input, 1: ADC word select, asynchronous; low = left, high = right.
REQ-007 SHALL have port AUD_ADCDAT, input, 1: ADC serial data, MSB first, I2S one-bit delay.
REQ-008 SHALL have port enable, input, 1: capture permitted when high.
REQ-009 SHALL have port sample_ready, input, 1: consumer accepts the pair when high with sample_valid.
REQ-010 SHALL have port left_sample, output, DATA_WIDTH: captured left word.
REQ-011 SHALL have port right_sample, output, DATA_WIDTH: captured right word.
REQ-012 SHALL have port sample_valid, output, 1: left/right pair pending.
REQ-013 SHALL have port overflow, output, 1: sticky flag, completed pair dropped.
REQ-014 SHALL have port frame_error, output, 1: sticky flag, channel shorter than DATA_WIDTH bits.
REQ-015 SHALL have port frame_count, output, 16: count of pairs delivered to the output register.

Function
REQ-016 SHALL pass AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT through SYNC_STAGES flops each; bclk_rise = synced BCLK 1 with previous synced value 0.
REQ-017 SHALL act only on cycles where bclk_rise is 1; it SHALL hold all other state on other cycles.
REQ-018 SHALL keep lr_prev, the synced LRCK sampled at the previous bclk_rise; an LRCK change = the current sample differs from lr_prev.
REQ-019 SHALL use states WAIT_FRAME, LEFT_DELAY, LEFT_SHIFT, RIGHT_DELAY, RIGHT_SHIFT.
REQ-020 In WAIT_FRAME, an LRCK 1->0 change with enable=1 SHALL go to LEFT_SHIFT; that rise is the delay slot and its data bit is discarded.
REQ-021 LEFT_DELAY/RIGHT_DELAY are that delay slot: each is entered on the LRCK change and exits to its SHIFT state on the same rise without capturing.
REQ-022 In a SHIFT state, each rise SHALL shift the data bit in at the LSB, and bit_cnt SHALL increment; bit_cnt is 0..DATA_WIDTH.
REQ-023 After DATA_WIDTH bits, further rises SHALL be ignored until the next LRCK change.
REQ-024 In LEFT_SHIFT, an LRCK 0->1 change SHALL go to RIGHT_SHIFT through RIGHT_DELAY and clear bit_cnt; the left word SHALL be latched only if bit_cnt==DATA_WIDTH.
REQ-025 In RIGHT_SHIFT, an LRCK 1->0 change with bit_cnt==DATA_WIDTH and a valid left word SHALL complete a pair; the state SHALL then go to LEFT_SHIFT through LEFT_DELAY.
REQ-026 An LRCK change with bit_cnt<DATA_WIDTH SHALL set frame_error, discard the partial pair, and restart at the new channel's delay slot.
REQ-027 A right channel starting after a discarded left SHALL be captured and then dropped; it SHALL NOT complete a pair.
REQ-028 A completed pair SHALL load left_sample, right_sample and set sample_valid, one clk after the completing bclk_rise cycle.
REQ-029 Handshake: a transfer occurs when sample_valid and sample_ready are both 1; sample_valid SHALL clear next cycle unless a new pair loads.
REQ-030 If a completion and a transfer fall in the same cycle, the new pair SHALL load and sample_valid SHALL stay 1.
REQ-031 If a completion occurs while sample_valid=1 and sample_ready=0, the new pair SHALL be dropped, overflow SHALL set, and the outputs SHALL be unchanged.
REQ-032 frame_count SHALL increment by 1 on every pair load and wrap from 0xFFFF to 0x0000.
REQ-033 enable=0 SHALL force WAIT_FRAME on the next clk; a pending output pair and its handshake SHALL be unaffected.
REQ-034 Output registers SHALL be stable while sample_valid=1 and no load occurs.

Reset
REQ-035 On reset=1 at posedge clk: state=WAIT_FRAME, bit_cnt=0, shift registers 0, synchronizers 0, lr_prev=1.
REQ-036 On reset=1 at posedge clk: left_sample=0, right_sample=0, sample_valid=0, overflow=0, frame_error=0, frame_count=0.
REQ-037 Reset mid-frame SHALL discard the partial capture; capture SHALL resume at the first LRCK 1->0 change after release.
REQ-038 overflow and frame_error SHALL clear only on reset.

Verification
REQ-039 Scenario: BCLK = clk/8, 32 BCLK per channel, L=0xA5C3, R=0x1234, sample_ready=1 -> one sample_valid pulse with left=0xA5C3, right=0x1234, frame_count=1.
REQ-040 Scenario: two frames, sample_ready=0 throughout -> first pair held, overflow=1, frame_count=1, outputs still 0xA5C3/0x1234.
REQ-041 Scenario: left channel only 10 BCLK long -> frame_error=1, no pair loaded; next full frame L=0x00FF, R=0xFF00 -> delivered correctly.
REQ-042 Scenario: sample_ready asserted in the exact cycle a second pair completes -> no overflow, sample_valid stays 1, second pair visible, frame_count=2.
REQ-043 Scenario: enable=0 during a right channel, then 1 -> no pair from the interrupted frame; the next full frame is delivered.
REQ-044 Scenario: reset pulse mid-left-channel -> all outputs 0 next cycle; the first full frame after release is delivered with frame_count=1.
